// File: rtl/vga_capture.sv
// Recovers active-pixel timing from a raw VGA sync/colour stream, verifies line and
// frame geometry before locking, and emits registered pixel coordinates and colour.
module vga_capture #(
  parameter int H_TOTAL  = 800,
  parameter int H_SYNC   = 97,
  parameter int H_BACK   = 44,
  parameter int H_ACTIVE = 640,
  parameter int V_TOTAL  = 525,
  parameter int V_BACK   = 30,
  parameter int V_ACTIVE = 480
) (
  input  logic       clock_25MHz,
  input  logic       reset,
  input  logic       hsync_in,
  input  logic       vsync_in,
  input  logic       red_in,
  input  logic       green_in,
  input  logic       blue_in,
  output logic       pixel_valid,
  output logic [9:0] pixel_row,
  output logic [9:0] pixel_col,
  output logic       red_out,
  output logic       green_out,
  output logic       blue_out,
  output logic       frame_start,
  output logic       locked,
  output logic       timing_error
);

  typedef enum logic [1:0] {SEARCH = 2'd0, VERIFY = 2'd1, LOCKED = 2'd2} state_t;

  localparam logic [9:0]  H_MAX     = 10'd1023;
  localparam logic [6:0]  H_LOW_MAX = 7'd127;
  localparam logic [10:0] H_TOTAL_W = 11'(H_TOTAL);
  localparam logic [6:0]  H_SYNC_W  = 7'(H_SYNC);
  localparam logic [9:0]  H_FIRST   = 10'(H_BACK);
  localparam logic [9:0]  H_LAST    = 10'(H_BACK + H_ACTIVE - 1);
  localparam logic [9:0]  V_FIRST   = 10'(V_BACK);
  localparam logic [9:0]  V_LAST    = 10'(V_BACK + V_ACTIVE - 1);
  localparam logic [9:0]  V_TOTAL_W = 10'(V_TOTAL);

  state_t      state_q, state_d;
  logic        hs_q, hs_d, hs_prev_q, hs_prev_d;
  logic        vs_q, vs_d, vs_prev_q, vs_prev_d;
  logic [2:0]  rgb_q, rgb_d;
  logic [9:0]  h_meas_q, h_meas_d;
  logic [6:0]  h_low_q, h_low_d;
  logic [9:0]  v_line_q, v_line_d;
  logic        first_q, first_d;
  logic        valid_q, valid_d;
  logic [9:0]  row_q, row_d, col_q, col_d;
  logic [2:0]  rgb_out_q, rgb_out_d;
  logic        frame_start_q, frame_start_d;
  logic        locked_q, locked_d;
  logic        timing_error_q, timing_error_d;
  logic        hs_rise, vs_rise, line_err, frame_err, in_window;
  logic [10:0] h_meas_p1;

  always_comb begin
    hs_rise   = hs_q & ~hs_prev_q;
    vs_rise   = vs_q & ~vs_prev_q;
    h_meas_p1 = {1'b0, h_meas_q} + 11'd1;
    // The first line measured after entering VERIFY may be partial, so only its sync width counts.
    line_err  = (h_meas_q == H_MAX) |
                (hs_rise & ((h_low_q != H_SYNC_W) | (~first_q & (h_meas_p1 != H_TOTAL_W))));
    frame_err = vs_rise & (v_line_q != V_TOTAL_W);
    in_window = (h_meas_q >= H_FIRST) && (h_meas_q <= H_LAST) &&
                (v_line_q >= V_FIRST) && (v_line_q <= V_LAST);
  end

  always_comb begin
    hs_d      = hsync_in;
    vs_d      = vsync_in;
    hs_prev_d = hs_q;
    vs_prev_d = vs_q;
    rgb_d     = {red_in, green_in, blue_in};
    if (hs_rise) begin
      h_meas_d = 10'd0;
    end else if (h_meas_q == H_MAX) begin
      h_meas_d = H_MAX;
    end else begin
      h_meas_d = h_meas_q + 10'd1;
    end
    if (hs_q) begin
      h_low_d = 7'd0;
    end else if (h_low_q == H_LOW_MAX) begin
      h_low_d = H_LOW_MAX;
    end else begin
      h_low_d = h_low_q + 7'd1;
    end
    if (vs_rise) begin
      v_line_d = hs_rise ? 10'd1 : 10'd0;
    end else if (hs_rise && (v_line_q != 10'd1023)) begin
      v_line_d = v_line_q + 10'd1;
    end else begin
      v_line_d = v_line_q;
    end
    if ((state_q == SEARCH) && (state_d == VERIFY)) begin
      first_d = 1'b1;
    end else if ((state_q == VERIFY) && hs_rise) begin
      first_d = 1'b0;
    end else begin
      first_d = first_q;
    end
  end

  // Sync sample flops idle high so leaving reset never fakes a sync rise.
  always_ff @(posedge clock_25MHz) begin
    if (reset) begin
      hs_q           <= 1'b1;
      hs_prev_q      <= 1'b1;
      vs_q           <= 1'b1;
      vs_prev_q      <= 1'b1;
      rgb_q          <= 3'd0;
      h_meas_q       <= 10'd0;
      h_low_q        <= 7'd0;
      v_line_q       <= 10'd0;
      first_q        <= 1'b0;
      valid_q        <= 1'b0;
      row_q          <= 10'd0;
      col_q          <= 10'd0;
      rgb_out_q      <= 3'd0;
      frame_start_q  <= 1'b0;
      locked_q       <= 1'b0;
      timing_error_q <= 1'b0;
    end else begin
      hs_q           <= hs_d;
      hs_prev_q      <= hs_prev_d;
      vs_q           <= vs_d;
      vs_prev_q      <= vs_prev_d;
      rgb_q          <= rgb_d;
      h_meas_q       <= h_meas_d;
      h_low_q        <= h_low_d;
      v_line_q       <= v_line_d;
      first_q        <= first_d;
      valid_q        <= valid_d;
      row_q          <= row_d;
      col_q          <= col_d;
      rgb_out_q      <= rgb_out_d;
      frame_start_q  <= frame_start_d;
      locked_q       <= locked_d;
      timing_error_q <= timing_error_d;
    end
  end

  always_ff @(posedge clock_25MHz) begin
    if (reset) begin
      state_q <= SEARCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      SEARCH: begin
        if (vs_rise) begin
          state_d = VERIFY;
        end else begin
          state_d = SEARCH;
        end
      end
      VERIFY: begin
        if (line_err || frame_err) begin
          state_d = SEARCH;
        end else if (vs_rise) begin
          state_d = LOCKED;
        end else begin
          state_d = VERIFY;
        end
      end
      LOCKED: begin
        if (line_err || frame_err) begin
          state_d = SEARCH;
        end else begin
          state_d = LOCKED;
        end
      end
      default: state_d = SEARCH;
    endcase
  end

  // Only errors leave VERIFY/LOCKED for SEARCH, so that transition is the error pulse.
  always_comb begin
    locked_d       = (state_d == LOCKED);
    timing_error_d = (state_d == SEARCH) && (state_q != SEARCH);
    valid_d        = (state_q == LOCKED) && (state_d == LOCKED) && in_window;
    if (valid_d) begin
      col_d     = h_meas_q - H_FIRST;
      row_d     = v_line_q - V_FIRST;
      rgb_out_d = rgb_q;
    end else begin
      col_d     = col_q;
      row_d     = row_q;
      rgb_out_d = 3'd0;
    end
    frame_start_d = valid_d && (h_meas_q == H_FIRST) && (v_line_q == V_FIRST);
  end

  assign pixel_valid  = valid_q;
  assign pixel_row    = row_q;
  assign pixel_col    = col_q;
  assign red_out      = rgb_out_q[2];
  assign green_out    = rgb_out_q[1];
  assign blue_out     = rgb_out_q[0];
  assign frame_start  = frame_start_q;
  assign locked       = locked_q;
  assign timing_error = timing_error_q;

endmodule

// File: doc/vga_capture.md
VGA_CAPTURE -- requirements
Module: vga_capture

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- H_TOTAL, 800, clocks per line.
- H_SYNC, 97, hsync low width in clocks.
- H_BACK, 44, clocks from first sampled-high hsync to first active pixel.
- H_ACTIVE, 640, active pixels per line.
- V_TOTAL, 525, hsync rising edges per frame.
- V_BACK, 30, hsync rising edges from vsync rise to first active line.
- V_ACTIVE, 480, active lines per frame.
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
- clock_25MHz  input  1  sole clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- hsync_in  input  1  horizontal sync, active low.
- vsync_in  input  1  vertical sync, active low.
- red_in / green_in / blue_in  input  1 each  pixel colour.
- pixel_valid  output  1  high for each recovered active pixel.
- pixel_row  output  10  active row 0..V_ACTIVE-1.
- pixel_col  output  10  active column 0..H_ACTIVE-1.
- red_out / green_out / blue_out  output  1 each  colour, forced 0 when pixel_valid low.
- frame_start  output  1  one-clock pulse coincident with pixel (0,0).
- locked  output  1  timing verified, capture active.
- timing_error  output  1  one-clock pulse on any detected timing violation.
REQ-003 Clock and reset SHALL be one clock, clock_25MHz; reset synchronous and active-high.

Function
REQ-004 All inputs SHALL be registered once ("sample"); edges SHALL be detected by comparing sample with its previous value.
REQ-005 Hsync rise = sample high, previous low; vsync rise likewise.
REQ-006 h_meas (10 bit) SHALL clear to 0 on hsync rise, else increment, saturating at 1023.
REQ-007 h_low (7 bit) SHALL count consecutive low hsync samples, saturating at 127; checked at hsync rise.
REQ-008 v_line (10 bit) SHALL clear on vsync rise and increment on every hsync rise; if both coincide, v_line SHALL become 1.
REQ-009 Line error: at hsync rise, h_meas+1 != H_TOTAL or h_low != H_SYNC (first rise after entering VERIFY exempt from h_meas check); or h_meas reaches 1023.
REQ-010 Frame error: at vsync rise, v_line != V_TOTAL (first vsync rise after SEARCH exempt).
REQ-011 FSM states SEARCH, VERIFY, LOCKED; reset enters SEARCH.
- SEARCH: on vsync rise -> VERIFY.
- VERIFY: line error -> SEARCH; vsync rise with v_line == V_TOTAL and no error -> LOCKED; v_line != V_TOTAL -> SEARCH.
- LOCKED: any line or frame error -> SEARCH.
REQ-012 Every transition to SEARCH on an error SHALL pulse timing_error for exactly one clock.
REQ-013 locked SHALL be high exactly while state is LOCKED, registered.
REQ-014 In LOCKED, a pixel is active when h_meas in [H_BACK, H_BACK+H_ACTIVE-1] and v_line in [V_BACK, V_BACK+V_ACTIVE-1]; pixel_col = h_meas-H_BACK, pixel_row = v_line-V_BACK.
REQ-015 Outputs SHALL be registered: pixel colour on pins appears on *_out 2 clocks later with matching row/col and pixel_valid.
REQ-016 frame_start SHALL pulse with pixel_valid when pixel_row=0 and pixel_col=0.
REQ-017 When pixel_valid low, pixel_row/pixel_col SHALL hold last value and *_out SHALL be 0.
REQ-018 Error in LOCKED SHALL drop pixel_valid the clock after the error is detected; no partial-line output afterwards.

Reset
REQ-019 While reset high: state SEARCH; all counters 0; every output 0; outputs low first clock after reset deasserts.
REQ-020 Reset mid-frame SHALL abandon lock; relock requires a fresh VERIFY frame.

Verification
REQ-021 Clean 800x525 stream (hsync low 97, vsync low 2 lines) from reset -> locked rises at second vsync rise; no timing_error.
REQ-022 Locked stream, pixel at 44 clocks after hsync rise on line v_line=30 -> pixel_valid, row 0, col 0, frame_start pulse, colour matches 2 clocks later.
REQ-023 Locked, one line of 799 clocks -> single timing_error pulse, locked falls, pixel_valid 0; relock after 2 clean vsync rises.
REQ-024 Locked, hsync held high 1100 clocks -> error at h_meas=1023, state SEARCH.
REQ-025 VERIFY frame of 524 lines -> timing_error, back to SEARCH, locked stays 0.
REQ-026 Reset pulsed mid-active-line while locked -> all outputs 0 next clock, relock after 2 vsync rises.
